// File: rtl/mem_bus_router.sv
// Registered N-way router for the core's native memory bus. Decodes the request
// address against a parametrised map, forwards it to one target and returns its response.
module mem_bus_router #(
  parameter int                         N_SLAVES  = 4,
  parameter int                         ADDR_W    = 32,
  parameter int                         DATA_W    = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE  = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK  = {N_SLAVES{32'h0}},
  parameter int                         TIMEOUT   = 255,
  parameter logic [DATA_W-1:0]          ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic                         m_instr,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [N_SLAVES-1:0]          s_valid,
  output logic                         s_instr,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [N_SLAVES-1:0]          s_ready,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  output logic                         err_irq,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [7:0]                   err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t              state;
  state_t              state_next;
  logic [N_SLAVES-1:0] hit_oh;
  logic                hit_any;
  logic [N_SLAVES-1:0] sel_oh;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout_hit;
  logic [15:0]         wait_cnt;

  // Address decode; the found flag makes the lowest-index match win on overlaps.
  always_comb begin
    hit_oh  = '0;
    hit_any = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit_any &&
          ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_oh[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
    sel_ready   = |(s_ready & sel_oh);
    timeout_hit = (wait_cnt == LAST_WAIT);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (m_valid) state_next = hit_any ? ACCESS : ERR;
      ACCESS:  if (sel_ready || timeout_hit) state_next = RESP;
      ERR:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath; a ready on the final wait cycle takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_instr   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      sel_oh    <= '0;
      wait_cnt  <= '0;
      err_irq   <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      m_ready <= 1'b0;
      err_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_instr  <= m_instr;
            s_addr   <= m_addr;
            s_wdata  <= m_wdata;
            s_wstrb  <= m_wstrb;
            sel_oh   <= hit_oh;
            s_valid  <= hit_oh;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            s_valid <= '0;
            m_rdata <= sel_rdata;
            m_ready <= 1'b1;
          end else if (timeout_hit) begin
            s_valid  <= '0;
            m_rdata  <= ERR_RDATA;
            m_ready  <= 1'b1;
            err_irq  <= 1'b1;
            err_addr <= s_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ERR: begin
          m_rdata  <= ERR_RDATA;
          m_ready  <= 1'b1;
          err_irq  <= 1'b1;
          err_addr <= s_addr;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
